tex_dcr_unit: RTL and testbench
===============================

# tex_dcr_unit

Device-configuration-register front end for the texture unit. Captures DCR writes from the host/command path into per-stage shadow state. On an explicit commit it publishes that state as a `tex_dcrs_t` active copy per texture stage. It serves stage lookups to the downstream texture address/sampler pipeline through a valid/ready request-response port with one-cycle latency.

## Interface
- `NUM_STAGES`, 2: texture stages held; `STAGE_BITS = max(1, $clog2(NUM_STAGES))`.
- `DCR_ADDR_BITS`, 12: DCR address width.
- `DCR_DATA_BITS`, 32: DCR data width.
- `DCR_TEX_BASE`, 12'h100: base address of the texture DCR window.
- `clk` in 1: clock.
- `reset_n` in 1: reset; one clock, asynchronous assert, active-low.
- `dcr_wr_valid` in 1: DCR write strobe.
- `dcr_wr_addr` in DCR_ADDR_BITS: write address.
- `dcr_wr_data` in DCR_DATA_BITS: write data.
- `dcr_wr_ready` out 1: write accepted; 0 in reset, 1 otherwise.
- `req_valid` in 1: lookup request.
- `req_stage` in STAGE_BITS: stage to read.
- `req_ready` out 1: request accepted.
- `rsp_valid` out 1: response valid.
- `rsp_dcrs` out $bits(tex_dcrs_t): active state of the requested stage.
- `rsp_ready` in 1: downstream accepts the response.

## Operation
- Address map, offset = `dcr_wr_addr - DCR_TEX_BASE`:
  - 0 STAGE
  - 1 ADDR → baddr
  - 2 LOGDIM: u=[LOD_BITS-1:0], v=[16+LOD_BITS-1:16]
  - 3 FORMAT
  - 4 FILTER
  - 5 WRAP: u=[WRAP_BITS-1:0], v=[16+WRAP_BITS-1:16]
  - 6 COMMIT, data ignored
  - 7+i MIPOFF[i], i = 0..TEX_LOD_MAX
- Fields take the LSBs of the data. Excess bits are dropped.
- Offsets outside the map, or addresses below the base, are ignored with no state change.
- STAGE write: sets `cur_stage` when data < NUM_STAGES. Otherwise `cur_stage` is unchanged.
- Field writes update `shadow[cur_stage]` only.
- COMMIT copies `shadow[cur_stage]` to `active[cur_stage]`. Other stages and shadow contents are untouched.
- Read path: a request is accepted when `req_valid && req_ready`, with `req_ready = !rsp_valid || rsp_ready`.
  - On accept, `rsp_dcrs <= active[req_stage]` and `rsp_valid <= 1`.
  - If `req_stage >= NUM_STAGES`, the response is all-zero, still with `rsp_valid = 1`.
- `rsp_valid` clears when `rsp_ready` is high and no new request is accepted.
- While stalled (`rsp_valid && !rsp_ready`), `rsp_dcrs` holds stable and a later COMMIT does not alter it.

## Timing
- Reset values:
  - `rsp_valid` 0, `rsp_dcrs` 0, `dcr_wr_ready` 0.
  - `cur_stage` 0.
  - All shadow and active fields 0.
- `req_ready` is combinational from `rsp_valid`/`rsp_ready`; it reads 1 in reset.
- Write effect: shadow/active values are visible to a request accepted in cycle N+1 after a write at cycle N.
- Same-cycle COMMIT and request accept on the same stage: the response carries the pre-commit value.
- Read latency is 1 cycle. Back-to-back requests sustain 1 per cycle when `rsp_ready = 1`.
- Reset mid-operation:
  - Asynchronously drops `rsp_valid` and clears all state.
  - In-flight responses are lost.
  - After deassertion, the first accepted request returns zeros.

## Structure
- Add to package `tex_types`:
  - DCR offset constants `TEX_DCR_STAGE`..`TEX_DCR_MIPOFF0`.
  - `TEX_DCR_NUM = 7 + TEX_LOD_MAX + 1`.
- `tex_dcrs_t` stays in `tex_types`. Both the shadow and active arrays use it.
- One sub-module: `tex_dcr_rsp_buf`, a single-entry valid/ready output register, parameterised on data width.
- Write decode and the bank arrays stay in the top module.

## Test plan
- Reset, then request stage 0 → `rsp_valid` 1 cycle later, `rsp_dcrs` == 0. `req_ready` == 1 throughout.
- STAGE=1, ADDR=0x8000_0040, LOGDIM=0x0009_0008, COMMIT, request stage 1 → baddr=0x8000_0040, logdims u=8, v=9. A request for stage 0 is still 0.
- Write ADDR=0x1234 to stage 0 without COMMIT, then request stage 0 → baddr=0. After COMMIT, a request → 0x1234.
- COMMIT and request accept on stage 0 in the same cycle → response carries the old baddr. The request in the next cycle carries the new one.
- Hold `rsp_ready`=0 for 3 cycles with a pending response; COMMIT new data meanwhile → `rsp_dcrs` unchanged and `req_ready`=0. On release, the queued request returns the new data.
- STAGE=5 (NUM_STAGES=2) then ADDR write → applies to the previous stage. Assert `reset_n`=0 mid-stall → `rsp_valid` drops immediately and all fields read 0 afterwards.

Source files
------------

// File: rtl/tex_types.sv
// tex_types: shared texture-unit types and constants.
// Holds the per-stage texture DCR record (tex_dcrs_t) and the DCR
// offsets of the texture window relative to its base address.
package tex_types;

  localparam int TEX_LOD_MAX     = 11;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 2;
  localparam int TEX_WRAP_BITS   = 3;
  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_MIPOFF_BITS = 25;
  localparam int TEX_MIP_IDX_BITS = $clog2(TEX_LOD_MAX + 1);

  // DCR offsets within the texture window
  localparam int TEX_DCR_OFF_BITS = 5;
  localparam logic [TEX_DCR_OFF_BITS-1:0] TEX_DCR_STAGE   = 5'd0;
  localparam logic [TEX_DCR_OFF_BITS-1:0] TEX_DCR_ADDR    = 5'd1;
  localparam logic [TEX_DCR_OFF_BITS-1:0] TEX_DCR_LOGDIM  = 5'd2;
  localparam logic [TEX_DCR_OFF_BITS-1:0] TEX_DCR_FORMAT  = 5'd3;
  localparam logic [TEX_DCR_OFF_BITS-1:0] TEX_DCR_FILTER  = 5'd4;
  localparam logic [TEX_DCR_OFF_BITS-1:0] TEX_DCR_WRAP    = 5'd5;
  localparam logic [TEX_DCR_OFF_BITS-1:0] TEX_DCR_COMMIT  = 5'd6;
  localparam logic [TEX_DCR_OFF_BITS-1:0] TEX_DCR_MIPOFF0 = 5'd7;
  localparam int TEX_DCR_NUM = 7 + TEX_LOD_MAX + 1;

  // logdims/wraps: index 0 = u, index 1 = v
  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                     baddr;
    logic [1:0][TEX_LOD_BITS-1:0]                 logdims;
    logic [TEX_FORMAT_BITS-1:0]                   format;
    logic [TEX_FILTER_BITS-1:0]                   filter;
    logic [1:0][TEX_WRAP_BITS-1:0]                wraps;
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]    mipoff;
  } tex_dcrs_t;

endpackage

// File: rtl/tex_dcr_rsp_buf.sv
// tex_dcr_rsp_buf: single-entry valid/ready output register.
// Ports: clk, rst_n (async, active-low); i_valid/o_ready/i_data upstream;
// o_valid/i_ready/o_data downstream. o_ready is combinational so a full
// buffer that is draining this cycle can take a new entry (1/cycle).
module tex_dcr_rsp_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Data is only loaded on accept, so it holds stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tex_dcr_unit.sv
// tex_dcr_unit: texture DCR front end.
// DCR writes (dcr_wr_*) land in per-stage shadow state selected by the
// STAGE register; COMMIT publishes shadow to active for the current stage.
// Lookups (req_valid/req_stage/req_ready) return the active record of a
// stage on rsp_valid/rsp_dcrs one cycle later, with rsp_ready back-pressure.
// clk, reset_n: clock and asynchronous active-low reset.
module tex_dcr_unit
  import tex_types::*;
#(
  parameter int NUM_STAGES    = 2,
  parameter int DCR_ADDR_BITS = 12,
  parameter int DCR_DATA_BITS = 32,
  parameter logic [DCR_ADDR_BITS-1:0] DCR_TEX_BASE = 12'h100,
  localparam int STAGE_BITS   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        dcr_wr_valid,
  input  logic [DCR_ADDR_BITS-1:0]    dcr_wr_addr,
  input  logic [DCR_DATA_BITS-1:0]    dcr_wr_data,
  output logic                        dcr_wr_ready,
  input  logic                        req_valid,
  input  logic [STAGE_BITS-1:0]       req_stage,
  output logic                        req_ready,
  output logic                        rsp_valid,
  output logic [$bits(tex_dcrs_t)-1:0] rsp_dcrs,
  input  logic                        rsp_ready
);

  logic                         r_wr_ready;
  logic [STAGE_BITS-1:0]        r_cur_stage;
  tex_dcrs_t                    r_shadow [NUM_STAGES];
  tex_dcrs_t                    r_active [NUM_STAGES];

  logic [DCR_ADDR_BITS-1:0]     w_off_full;
  logic [TEX_DCR_OFF_BITS-1:0]  w_off;
  logic [TEX_MIP_IDX_BITS-1:0]  w_mip_idx;
  logic                         w_wr_hit;
  logic                         w_stage_ok;
  tex_dcrs_t                    w_rd_data;

  assign dcr_wr_ready = r_wr_ready;

  // Addresses below the base wrap to a huge offset, but the explicit
  // base compare keeps that intent obvious for other base/width choices.
  assign w_off_full = dcr_wr_addr - DCR_TEX_BASE;
  assign w_off      = w_off_full[TEX_DCR_OFF_BITS-1:0];
  assign w_mip_idx  = TEX_MIP_IDX_BITS'(w_off - TEX_DCR_MIPOFF0);
  assign w_wr_hit   = dcr_wr_valid && r_wr_ready
                   && (dcr_wr_addr >= DCR_TEX_BASE)
                   && (w_off_full < DCR_ADDR_BITS'(TEX_DCR_NUM));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ready  <= 1'b0;
      r_cur_stage <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_shadow[s] <= '0;
        r_active[s] <= '0;
      end
    end else begin
      r_wr_ready <= 1'b1;
      if (w_wr_hit) begin
        case (w_off)
          TEX_DCR_STAGE: begin
            if (dcr_wr_data < DCR_DATA_BITS'(NUM_STAGES))
              r_cur_stage <= dcr_wr_data[STAGE_BITS-1:0];
          end
          TEX_DCR_ADDR:
            r_shadow[r_cur_stage].baddr <= dcr_wr_data[TEX_ADDR_BITS-1:0];
          TEX_DCR_LOGDIM: begin
            r_shadow[r_cur_stage].logdims[0] <= dcr_wr_data[TEX_LOD_BITS-1:0];
            r_shadow[r_cur_stage].logdims[1] <= dcr_wr_data[16 +: TEX_LOD_BITS];
          end
          TEX_DCR_FORMAT:
            r_shadow[r_cur_stage].format <= dcr_wr_data[TEX_FORMAT_BITS-1:0];
          TEX_DCR_FILTER:
            r_shadow[r_cur_stage].filter <= dcr_wr_data[TEX_FILTER_BITS-1:0];
          TEX_DCR_WRAP: begin
            r_shadow[r_cur_stage].wraps[0] <= dcr_wr_data[TEX_WRAP_BITS-1:0];
            r_shadow[r_cur_stage].wraps[1] <= dcr_wr_data[16 +: TEX_WRAP_BITS];
          end
          TEX_DCR_COMMIT:
            r_active[r_cur_stage] <= r_shadow[r_cur_stage];
          default: begin
            if (w_off >= TEX_DCR_MIPOFF0)
              r_shadow[r_cur_stage].mipoff[w_mip_idx] <=
                dcr_wr_data[TEX_MIPOFF_BITS-1:0];
          end
        endcase
      end
    end
  end

  // Read samples active before this edge's COMMIT lands, so a same-cycle
  // commit and accept returns the pre-commit record.
  assign w_stage_ok = (32'(req_stage) < NUM_STAGES);
  assign w_rd_data  = w_stage_ok ? r_active[req_stage] : '0;

  tex_dcr_rsp_buf #(
    .DATA_W ($bits(tex_dcrs_t))
  ) u_rsp_buf (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_valid (req_valid),
    .o_ready (req_ready),
    .i_data  (w_rd_data),
    .o_valid (rsp_valid),
    .i_ready (rsp_ready),
    .o_data  (rsp_dcrs)
  );

endmodule

// File: tb/tb_tex_dcr_unit.sv
module tb_tex_dcr_unit;
  import tex_types::*;

  localparam logic [11:0] BASE = 12'h100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dcr_wr_valid;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic        dcr_wr_ready;
  logic        req_valid;
  logic [0:0]  req_stage;
  logic        req_ready;
  logic        rsp_valid;
  logic [$bits(tex_dcrs_t)-1:0] rsp_dcrs;
  logic        rsp_ready;
  tex_dcrs_t   d;

  int n_tests = 0;
  int n_fail  = 0;

  assign d = tex_dcrs_t'(rsp_dcrs);

  always #5 clk = ~clk;

  tex_dcr_unit #(
    .NUM_STAGES    (2),
    .DCR_ADDR_BITS (12),
    .DCR_DATA_BITS (32),
    .DCR_TEX_BASE  (BASE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dcr_wr_valid (dcr_wr_valid),
    .dcr_wr_addr  (dcr_wr_addr),
    .dcr_wr_data  (dcr_wr_data),
    .dcr_wr_ready (dcr_wr_ready),
    .req_valid    (req_valid),
    .req_stage    (req_stage),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_dcrs     (rsp_dcrs),
    .rsp_ready    (rsp_ready)
  );

  task automatic check(input string tag, input logic [383:0] got,
                       input logic [383:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = addr;
    dcr_wr_data  = data;
    tick();
    dcr_wr_valid = 1'b0;
  endtask

  task automatic do_req(input logic [0:0] s);
    req_valid = 1'b1;
    req_stage = s;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; dcr_wr_valid = 1'b0; dcr_wr_addr = '0; dcr_wr_data = '0;
    req_valid = 1'b0; req_stage = '0; rsp_ready = 1'b1;

    // reset state
    #12;
    check("rst_wr_ready", dcr_wr_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dcrs", rsp_dcrs, 0);
    check("rst_req_ready", req_ready, 1);
    #5 reset_n = 1'b1;
    tick();
    check("wr_ready_up", dcr_wr_ready, 1);

    // first request after reset returns zeros, one cycle latency
    do_req(1'b0);
    check("r0_valid", rsp_valid, 1);
    check("r0_data", rsp_dcrs, 0);
    check("r0_req_ready", req_ready, 1);
    tick();
    check("r0_drain", rsp_valid, 0);

    // program stage 1, with a few out-of-window writes mixed in
    wr(BASE + 0, 32'd1);
    wr(BASE + 1, 32'h8000_0040);
    wr(BASE + 2, 32'h0009_0008);
    wr(BASE + 3, 32'hFD);
    wr(BASE + 4, 32'h2);
    wr(BASE + 5, 32'h0002_0001);
    wr(BASE + 7, 32'h123);
    wr(BASE + 18, 32'hF1AB_CDEF);
    wr(BASE + 19, 32'hFFFF_FFFF);
    wr(12'h0FF, 32'hFFFF_FFFF);
    wr(BASE + 6, 32'h0);
    do_req(1'b1);
    check("s1_baddr", d.baddr, 32'h8000_0040);
    check("s1_logu", d.logdims[0], 4'd8);
    check("s1_logv", d.logdims[1], 4'd9);
    check("s1_format", d.format, 3'd5);
    check("s1_filter", d.filter, 2'd2);
    check("s1_wrapu", d.wraps[0], 3'd1);
    check("s1_wrapv", d.wraps[1], 3'd2);
    check("s1_mip0", d.mipoff[0], 25'h123);
    check("s1_mip11", d.mipoff[11], 25'h1AB_CDEF);
    check("s1_mip5", d.mipoff[5], 25'h0);
    do_req(1'b0);
    check("s0_still_zero", rsp_dcrs, 0);

    // shadow not visible until commit
    wr(BASE + 0, 32'd0);
    wr(BASE + 1, 32'h1234);
    do_req(1'b0);
    check("nocommit_baddr", d.baddr, 32'h0);
    wr(BASE + 6, 32'h0);
    do_req(1'b0);
    check("commit_baddr", d.baddr, 32'h1234);

    // same-cycle commit and accept: old value, then new
    wr(BASE + 1, 32'h5678);
    dcr_wr_valid = 1'b1; dcr_wr_addr = BASE + 6; dcr_wr_data = '0;
    req_valid = 1'b1; req_stage = 1'b0;
    tick();
    dcr_wr_valid = 1'b0; req_valid = 1'b0;
    check("samecyc_old", d.baddr, 32'h1234);
    do_req(1'b0);
    check("samecyc_new", d.baddr, 32'h5678);
    tick();

    // stall for 3 cycles, commit new data underneath
    rsp_ready = 1'b0;
    do_req(1'b0);
    check("stall_valid", rsp_valid, 1);
    req_valid = 1'b1; req_stage = 1'b0;
    #1 check("stall_req_ready0", req_ready, 0);
    wr(BASE + 1, 32'h9ABC);
    check("stall_hold1", d.baddr, 32'h5678);
    wr(BASE + 6, 32'h0);
    check("stall_hold2", d.baddr, 32'h5678);
    check("stall_req_ready2", req_ready, 0);
    tick();
    check("stall_hold3", d.baddr, 32'h5678);
    check("stall_valid3", rsp_valid, 1);
    rsp_ready = 1'b1;
    #1 check("release_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("release_new", d.baddr, 32'h9ABC);
    check("release_valid", rsp_valid, 1);
    tick();
    check("release_drain", rsp_valid, 0);

    // illegal STAGE leaves current stage (0) selected
    wr(BASE + 0, 32'd5);
    wr(BASE + 1, 32'hDEAD);
    wr(BASE + 6, 32'h0);
    do_req(1'b0);
    check("badstage_s0", d.baddr, 32'hDEAD);
    do_req(1'b1);
    check("badstage_s1", d.baddr, 32'h8000_0040);
    tick();

    // asynchronous reset during a stall
    rsp_ready = 1'b0;
    do_req(1'b1);
    check("pre_rst_valid", rsp_valid, 1);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 0);
    check("midrst_dcrs", rsp_dcrs, 0);
    check("midrst_wr_ready", dcr_wr_ready, 0);
    check("midrst_req_ready", req_ready, 1);
    #3 reset_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    do_req(1'b1);
    check("postrst_s1", rsp_dcrs, 0);
    check("postrst_valid", rsp_valid, 1);
    do_req(1'b0);
    check("postrst_s0", rsp_dcrs, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
